// File: rtl/serv_shift_sched_if.sv
// Handshake bundle between two shift requesters, the scheduler and the bit-serial shifter.
// The slave modport is the scheduler's view; master is the requester/shifter side.
interface serv_shift_sched_if #(
    parameter int W = 32
);
    localparam int CW = $clog2(W);

    logic [1:0]      i_req;
    logic [2*CW-1:0] i_shamt;
    logic [1:0]      i_right;
    logic [1:0]      i_signbit;
    logic            i_sh_done;
    logic [1:0]      o_gnt;
    logic [1:0]      o_ack;
    logic            o_busy;
    logic            o_sh_load;
    logic [CW-1:0]   o_sh_shamt;
    logic            o_sh_right;
    logic            o_sh_signbit;
    logic            o_en;

    modport slave (
        input  i_req, i_shamt, i_right, i_signbit, i_sh_done,
        output o_gnt, o_ack, o_busy, o_sh_load, o_sh_shamt, o_sh_right, o_sh_signbit, o_en
    );

    modport master (
        output i_req, i_shamt, i_right, i_signbit, i_sh_done,
        input  o_gnt, o_ack, o_busy, o_sh_load, o_sh_shamt, o_sh_right, o_sh_signbit, o_en
    );
endinterface

// File: rtl/serv_shift_sched.sv
// Two-requester scheduler sharing one bit-serial shifter: arbitrate, load, skip, run W bits, ack.
// Define SERV_SHIFT_SCHED_RR_EN for round-robin tie breaking; otherwise requester 0 has priority.
module serv_shift_sched #(
    parameter int W = 32
) (
    input logic              i_clk,
    input logic              i_rst_n,
    serv_shift_sched_if.slave bus
);
    localparam int CW = $clog2(W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SKIP,
        ST_RUN,
        ST_ACK
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] sh_shamt_reg;
    logic          sh_right_reg;
    logic          sh_signbit_reg;
    logic [1:0]    gnt_reg;
    logic [1:0]    ack_reg;
    logic          busy_reg;
    logic          load_reg;
    logic          en_reg;
    logic          win_next;

    logic [CW-1:0] shamt_arr [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_slice
        assign shamt_arr[gi] = bus.i_shamt[gi*CW +: CW];
    end

`ifdef SERV_SHIFT_SCHED_RR_EN
    logic rr_reg;

    // Pointer only matters on a tie; a lone request always wins.
    always_comb begin
        win_next = bus.i_req[1];
        if (bus.i_req == 2'b11) begin
            win_next = rr_reg;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_reg <= 1'b0;
        end else if (state_reg == ST_ACK) begin
            rr_reg <= gnt_reg[0];
        end
    end
`else
    always_comb begin
        win_next = ~bus.i_req[0];
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            sh_shamt_reg   <= '0;
            sh_right_reg   <= 1'b0;
            sh_signbit_reg <= 1'b0;
            gnt_reg        <= 2'b00;
            ack_reg        <= 2'b00;
            busy_reg       <= 1'b0;
            load_reg       <= 1'b0;
            en_reg         <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.i_req != 2'b00) begin
                        state_reg      <= ST_LOAD;
                        gnt_reg        <= win_next ? 2'b10 : 2'b01;
                        sh_shamt_reg   <= shamt_arr[win_next];
                        sh_right_reg   <= bus.i_right[win_next];
                        sh_signbit_reg <= bus.i_signbit[win_next];
                        busy_reg       <= 1'b1;
                        load_reg       <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    load_reg <= 1'b0;
                    if (sh_right_reg) begin
                        state_reg <= ST_SKIP;
                    end else begin
                        state_reg <= ST_RUN;
                        en_reg    <= 1'b1;
                    end
                end
                ST_SKIP: begin
                    if (bus.i_sh_done) begin
                        state_reg <= ST_RUN;
                        en_reg    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cnt_reg == CW'(W - 1)) begin
                        state_reg <= ST_ACK;
                        cnt_reg   <= '0;
                        en_reg    <= 1'b0;
                        ack_reg   <= gnt_reg;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                ST_ACK: begin
                    state_reg <= ST_IDLE;
                    ack_reg   <= 2'b00;
                    gnt_reg   <= 2'b00;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_gnt        = gnt_reg;
    assign bus.o_ack        = ack_reg;
    assign bus.o_busy       = busy_reg;
    assign bus.o_sh_load    = load_reg;
    assign bus.o_sh_shamt   = sh_shamt_reg;
    assign bus.o_sh_right   = sh_right_reg;
    assign bus.o_sh_signbit = sh_signbit_reg;
    assign bus.o_en         = en_reg;
endmodule

// File: tb/tb_serv_shift_sched.sv
// Self-checking bench for serv_shift_sched: vector table, hand-written reset sequence, random ops.
// Expected timing comes from the operation's shamt/direction; the shifter's done flag is modelled.
module tb_serv_shift_sched;
    localparam int W  = 32;
    localparam int CW = 5;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic model_ptr;

    serv_shift_sched_if #(.W(W)) bus ();

    serv_shift_sched #(.W(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]      req;
        logic [2*CW-1:0] shamts;
        logic [1:0]      rights;
        logic [1:0]      signs;
        logic [1:0]      exp_gnt;
        logic [CW-1:0]   exp_s;
        logic            exp_r;
        logic            exp_sg;
        bit              mutate;
        bit              noise;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, k, act, exp);
        end
    endtask

    function automatic logic [6:0] ctl_now();
        return {bus.o_gnt, bus.o_ack, bus.o_busy, bus.o_sh_load, bus.o_en};
    endfunction

    function automatic logic [6:0] lat_now();
        return {bus.o_sh_shamt, bus.o_sh_right, bus.o_sh_signbit};
    endfunction

    // Called at a negedge while the DUT is idle; the coming posedge captures the request.
    task automatic do_op(input vec_t v);
        int run_start;
        int ack_k;
        bus.i_req     = v.req;
        bus.i_shamt   = v.shamts;
        bus.i_right   = v.rights;
        bus.i_signbit = v.signs;
        bus.i_sh_done = v.noise ? 1'($urandom) : 1'b0;
        run_start = v.exp_r ? int'(v.exp_s) + 3 : 2;
        ack_k     = run_start + W;
        for (int k = 1; k <= ack_k + 1; k++) begin
            @(negedge clk);
            chk("ctl", k, 16'(ctl_now()),
                16'({(k <= ack_k) ? v.exp_gnt : 2'b00,
                     (k == ack_k) ? v.exp_gnt : 2'b00,
                     k <= ack_k, k == 1,
                     (k >= run_start) && (k < run_start + W)}));
            if (k <= ack_k)
                chk("latched", k, 16'(lat_now()), 16'({v.exp_s, v.exp_r, v.exp_sg}));
            if (v.exp_r && k >= 2 && k <= 2 + int'(v.exp_s))
                bus.i_sh_done = (k == 2 + int'(v.exp_s));
            else
                bus.i_sh_done = v.noise ? 1'($urandom) : 1'b0;
            if (v.mutate && k == run_start + 3) begin
                bus.i_req     = 2'b00;
                bus.i_shamt   = ~bus.i_shamt;
                bus.i_right   = ~bus.i_right;
                bus.i_signbit = ~bus.i_signbit;
            end
        end
        if (v.mutate) begin
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                chk("idle_after_drop", k, 16'(ctl_now()), 16'd0);
            end
        end
    endtask

    initial begin
        vec_t v;
        logic [1:0] rq;
        logic       win;
        checks        = 0;
        failures      = 0;
        model_ptr     = 1'b0;
        rst_n         = 1'b0;
        bus.i_req     = 2'b00;
        bus.i_shamt   = '0;
        bus.i_right   = 2'b00;
        bus.i_signbit = 2'b00;
        bus.i_sh_done = 1'b0;

        tbl[0] = '{2'b01, {5'd0, 5'd0},  2'b00, 2'b00, 2'b01, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{2'b10, {5'd5, 5'd9},  2'b10, 2'b10, 2'b10, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{2'b11, {5'd12, 5'd3}, 2'b01, 2'b01, 2'b01, 5'd3,  1'b1, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{2'b01, {5'd1, 5'd17}, 2'b00, 2'b01, 2'b01, 5'd17, 1'b0, 1'b1, 1'b1, 1'b1};
`ifdef SERV_SHIFT_SCHED_RR_EN
        tbl[4] = '{2'b11, {5'd4, 5'd6},  2'b10, 2'b00, 2'b10, 5'd4,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{2'b11, {5'd8, 5'd2},  2'b00, 2'b11, 2'b01, 5'd2,  1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{2'b11, {5'd0, 5'd0},  2'b11, 2'b01, 2'b10, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1};
`else
        tbl[4] = '{2'b11, {5'd4, 5'd6},  2'b10, 2'b00, 2'b01, 5'd6,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{2'b11, {5'd8, 5'd2},  2'b00, 2'b11, 2'b01, 5'd2,  1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{2'b11, {5'd0, 5'd0},  2'b11, 2'b01, 2'b01, 5'd0,  1'b1, 1'b1, 1'b0, 1'b1};
`endif

        repeat (2) @(negedge clk);
        chk("reset_ctl", 0, 16'(ctl_now()), 16'd0);
        chk("reset_latched", 0, 16'(lat_now()), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ctl", 0, 16'(ctl_now()), 16'd0);

        for (int i = 0; i < 7; i++) begin
            do_op(tbl[i]);
            model_ptr = tbl[i].exp_gnt[0];
            $display("vec %0d req=%b gnt=%b shamt=%0d right=%b checks=%0d failures=%0d",
                     i, tbl[i].req, tbl[i].exp_gnt, tbl[i].exp_s, tbl[i].exp_r, checks, failures);
        end

        for (int i = 0; i < 24; i++) begin
            rq = 2'($urandom_range(1, 3));
`ifdef SERV_SHIFT_SCHED_RR_EN
            win = (rq == 2'b11) ? model_ptr : rq[1];
`else
            win = (rq == 2'b10);
`endif
            v.req     = rq;
            v.shamts  = 10'($urandom);
            v.rights  = 2'($urandom);
            v.signs   = 2'($urandom);
            v.exp_gnt = win ? 2'b10 : 2'b01;
            v.exp_s   = win ? v.shamts[9:5] : v.shamts[4:0];
            v.exp_r   = v.rights[win];
            v.exp_sg  = v.signs[win];
            v.mutate  = ($urandom_range(0, 1) == 1);
            v.noise   = 1'b1;
            do_op(v);
            model_ptr = ~win;
            $display("rnd %0d req=%b gnt=%b shamt=%0d right=%b checks=%0d failures=%0d",
                     i, rq, v.exp_gnt, v.exp_s, v.exp_r, checks, failures);
        end

        // Asynchronous reset in the middle of RUN, then a clean restart.
        bus.i_req     = 2'b01;
        bus.i_shamt   = {5'd0, 5'd7};
        bus.i_right   = 2'b00;
        bus.i_signbit = 2'b01;
        bus.i_sh_done = 1'b0;
        repeat (12) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_ctl", 0, 16'(ctl_now()), 16'd0);
        chk("async_reset_latched", 0, 16'(lat_now()), 16'd0);
        bus.i_req = 2'b00;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("held_reset_ctl", k, 16'(ctl_now()), 16'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", 0, 16'(ctl_now()), 16'd0);
        model_ptr = 1'b0;
        v = '{2'b11, {5'd9, 5'd3}, 2'b11, 2'b10, 2'b01, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1};
        do_op(v);
        $display("post-reset req=%b gnt=%b checks=%0d failures=%0d", v.req, v.exp_gnt, checks, failures);
        bus.i_req = 2'b00;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
